// File: rtl/alu_harness_pkg.sv
// Shared definitions for the ALU harness: record layout, opcode constants
// and the tracker state encoding.
package alu_harness_pkg;

   localparam int unsigned REC_W = 32;

   // One completed-operation record as seen by the C/Python side.
   typedef struct packed {
      logic [7:0]  seq;
      logic [2:0]  op;
      logic [4:0]  lat;
      logic [15:0] result;
   } alu_rec_t;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_SHR = 3'd7;

   localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;
   localparam logic [4:0]  LAT_MAX        = 5'd31;

   typedef enum logic {
      TRK_IDLE = 1'b0,
      TRK_BUSY = 1'b1
   } trk_state_t;

   // Saturating latency increment.
   function automatic logic [4:0] lat_sat_inc(input logic [4:0] lat);
      return (lat == LAT_MAX) ? LAT_MAX : lat + 5'd1;
   endfunction

endpackage

// File: rtl/alu_op_tracker.sv
// Follows one ALU op at a time (IDLE/BUSY), measures its latency and emits a
// one-cycle record strobe on completion. Optional timeout records are enabled
// by defining ALU_COLLECTOR_TIMEOUT_EN.
module alu_op_tracker
   import alu_harness_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 31
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic        done_i,
   input  logic [15:0] result_i,
   output logic        rec_valid_o,
   output alu_rec_t    rec_o
);

   trk_state_t  state_q;
   logic [2:0]  op_q;
   logic [4:0]  lat_q;
   logic [7:0]  seq_q;
   logic [4:0]  lat_inc;

`ifdef ALU_COLLECTOR_TIMEOUT_EN
   logic [15:0] to_cnt_q;
   logic        to_hit;
   assign to_hit = (32'(to_cnt_q) + 32'd1) >= TIMEOUT_CYC;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

   // Record strobe fires on the done-sample edge itself; the latency
   // reported includes that edge, hence the incremented value.
   always_comb begin
      lat_inc     = lat_sat_inc(lat_q);
      rec_valid_o = 1'b0;
      rec_o       = '{seq: seq_q, op: op_q, lat: lat_inc, result: result_i};
      if (state_q == TRK_BUSY) begin
         if (done_i) begin
            rec_valid_o = 1'b1;
         end
`ifdef ALU_COLLECTOR_TIMEOUT_EN
         else if (to_hit) begin
            rec_valid_o   = 1'b1;
            rec_o.lat     = LAT_MAX;
            rec_o.result  = TIMEOUT_RESULT;
         end
`endif
      end
   end

   // Monitor FSM with latency, sequence and timeout counters.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q  <= TRK_IDLE;
         op_q     <= OP_NOP;
         lat_q    <= '0;
         seq_q    <= '0;
`ifdef ALU_COLLECTOR_TIMEOUT_EN
         to_cnt_q <= '0;
`endif
      end else begin
         case (state_q)
            TRK_IDLE: begin
               if (start_i && (op_i != OP_NOP)) begin
                  state_q  <= TRK_BUSY;
                  op_q     <= op_i;
                  lat_q    <= '0;
`ifdef ALU_COLLECTOR_TIMEOUT_EN
                  to_cnt_q <= '0;
`endif
               end
            end
            TRK_BUSY: begin
               lat_q <= lat_inc;
`ifdef ALU_COLLECTOR_TIMEOUT_EN
               if (to_cnt_q != '1) begin
                  to_cnt_q <= to_cnt_q + 16'd1;
               end
`endif
               if (rec_valid_o) begin
                  state_q <= TRK_IDLE;
                  seq_q   <= seq_q + 8'd1;
               end
            end
            default: state_q <= TRK_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU completion records into a NUM_REC*32-bit packet and hands it
// off through valid/ready. Timeout records: define ALU_COLLECTOR_TIMEOUT_EN.
module alu_result_collector
   import alu_harness_pkg::*;
#(
   parameter int unsigned NUM_REC     = 192,
   parameter int unsigned TIMEOUT_CYC = 31
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       start_i,
   input  logic [2:0]                 op_i,
   input  logic                       done_i,
   input  logic [15:0]                result_i,
   input  logic                       flush_i,
   output logic                       pkt_valid_o,
   input  logic                       pkt_ready_i,
   output logic [NUM_REC*REC_W-1:0]   pkt_data_o,
   output logic [7:0]                 pkt_count_o,
   output logic [15:0]                drop_cnt_o
);

   localparam int unsigned PKT_W = NUM_REC * REC_W;
   localparam int unsigned IDX_W = $clog2(NUM_REC + 1);

   logic             rec_valid;
   alu_rec_t         rec;

   logic [PKT_W-1:0] buf_q,   buf_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic             valid_q, valid_d;
   logic [7:0]       count_q, count_d;
   logic [15:0]      drop_q,  drop_d;

   logic             xfer;
   logic             wr;
   logic             drop;
   logic [IDX_W-1:0] wr_idx;

   alu_op_tracker #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tracker (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .start_i     (start_i),
      .op_i        (op_i),
      .done_i      (done_i),
      .result_i    (result_i),
      .rec_valid_o (rec_valid),
      .rec_o       (rec)
   );

   // Buffer/handshake next state. A transfer clears the buffer first so a
   // record completing on the same edge lands in slot 0 of the new packet;
   // full/flush are evaluated after the write so the record is included.
   always_comb begin
      xfer    = valid_q & pkt_ready_i;
      wr      = rec_valid & (~valid_q | xfer);
      drop    = rec_valid & valid_q & ~xfer;
      wr_idx  = xfer ? '0 : idx_q;

      buf_d   = xfer ? '0 : buf_q;
      idx_d   = wr_idx;
      valid_d = valid_q & ~xfer;
      count_d = xfer ? '0 : count_q;
      drop_d  = drop_q;

      if (wr) begin
         buf_d[int'(wr_idx) * REC_W +: REC_W] = rec;
         idx_d = wr_idx + 1'b1;
      end

      if (drop && (drop_q != '1)) begin
         drop_d = drop_q + 16'd1;
      end

      if (idx_d == IDX_W'(NUM_REC)) begin
         valid_d = 1'b1;
         count_d = 8'(NUM_REC);
      end else if (flush_i && !valid_q && (idx_d != '0)) begin
         valid_d = 1'b1;
         count_d = 8'(idx_d);
      end
   end

   // Packet buffer, index, handshake and drop counter registers.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         buf_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

   assign pkt_valid_o = valid_q;
   assign pkt_data_o  = buf_q;
   assign pkt_count_o = count_q;
   assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector. Expected packets are queued as
// stimulus is issued; a monitor compares each packet at its transfer.
// Timeout scenario runs only when ALU_COLLECTOR_TIMEOUT_EN is defined.
module tb_alu_result_collector;

   localparam int NUM_REC = 192;
   localparam int PKT_W   = NUM_REC * 32;

   logic             clk;
   logic             reset_n_i;
   logic             start_i;
   logic [2:0]       op_i;
   logic             done_i;
   logic [15:0]      result_i;
   logic             flush_i;
   logic             pkt_valid_o;
   logic             pkt_ready_i;
   logic [PKT_W-1:0] pkt_data_o;
   logic [7:0]       pkt_count_o;
   logic [15:0]      drop_cnt_o;

   typedef struct {
      int               cnt;
      logic [PKT_W-1:0] data;
   } pkt_t;

   pkt_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   alu_result_collector #(
      .NUM_REC     (NUM_REC),
      .TIMEOUT_CYC (31)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n_i),
      .start_i     (start_i),
      .op_i        (op_i),
      .done_i      (done_i),
      .result_i    (result_i),
      .flush_i     (flush_i),
      .pkt_valid_o (pkt_valid_o),
      .pkt_ready_i (pkt_ready_i),
      .pkt_data_o  (pkt_data_o),
      .pkt_count_o (pkt_count_o),
      .drop_cnt_o  (drop_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mkrec(input int seq, input int op, input int lat, input int res);
      logic [7:0]  s = seq[7:0];
      logic [2:0]  o = op[2:0];
      logic [4:0]  l = lat[4:0];
      logic [15:0] r = res[15:0];
      return {s, o, l, r};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Issue one op; done is sampled dly edges after the start edge.
   task automatic do_op(input logic [2:0] op, input logic [15:0] res, input int dly, input bit rdy_at_done);
      start_i = 1'b1;
      op_i    = op;
      @(negedge clk);
      start_i = 1'b0;
      op_i    = 3'd0;
      repeat (dly - 1) @(negedge clk);
      done_i   = 1'b1;
      result_i = res;
      if (rdy_at_done) pkt_ready_i = 1'b1;
      @(negedge clk);
      done_i      = 1'b0;
      result_i    = '0;
      pkt_ready_i = 1'b0;
   endtask

   task automatic pulse_flush();
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
   endtask

   task automatic accept();
      pkt_ready_i = 1'b1;
      @(negedge clk);
      pkt_ready_i = 1'b0;
   endtask

   // Monitor: compare each packet as it is transferred.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (pkt_valid_o === 1'b1 && pkt_ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL sb_unexpected_pkt: got count %0d expected no packet", pkt_count_o);
            end else begin
               pkt_t e;
               int   bad;
               e   = sb_q.pop_front();
               bad = -1;
               chk("pkt_count", 32'(pkt_count_o), 32'(e.cnt));
               for (int k = 0; k < NUM_REC; k++)
                  if (bad < 0 && pkt_data_o[k*32 +: 32] !== e.data[k*32 +: 32]) bad = k;
               n_total++;
               if (bad < 0) n_pass++;
               else $display("FAIL pkt_data slot %0d: got %h expected %h",
                             bad, pkt_data_o[bad*32 +: 32], e.data[bad*32 +: 32]);
            end
         end
      end
   end

   initial begin
      pkt_t p;
      reset_n_i   = 1'b0;
      start_i     = 1'b0;
      op_i        = 3'd0;
      done_i      = 1'b0;
      result_i    = '0;
      flush_i     = 1'b0;
      pkt_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_valid", 32'(pkt_valid_o), 0);
      chk("reset_count", 32'(pkt_count_o), 0);
      chk("reset_drop",  32'(drop_cnt_o), 0);
      chk("reset_data_zero", 32'(pkt_data_o == '0), 1);
      reset_n_i = 1'b1;
      @(negedge clk);

      // Full packet of 192 ops, op=1, latency 3, result=k.
      p.cnt = NUM_REC;
      p.data = '0;
      for (int k = 0; k < NUM_REC; k++) p.data[k*32 +: 32] = mkrec(k, 1, 3, k);
      sb_q.push_back(p);
      for (int k = 0; k < NUM_REC; k++) do_op(3'd1, 16'(k), 3, 1'b0);
      chk("full_valid", 32'(pkt_valid_o), 1);
      chk("full_count", 32'(pkt_count_o), 192);

      // Ten more ops while unaccepted: dropped (seq 192..201).
      for (int k = 0; k < 10; k++) do_op(3'd2, 16'h0100 + 16'(k), 2, 1'b0);
      chk("drop_cnt_10", 32'(drop_cnt_o), 10);
      accept();
      chk("valid_after_xfer", 32'(pkt_valid_o), 0);

      // Five ops then flush; seq continues at 202, unused slots zero.
      p.cnt = 5;
      p.data = '0;
      for (int i = 0; i < 5; i++) p.data[i*32 +: 32] = mkrec(202 + i, i + 1, i + 1, 'hA000 + i);
      sb_q.push_back(p);
      for (int i = 0; i < 5; i++) do_op(3'(i + 1), 16'hA000 + 16'(i), i + 1, 1'b0);
      chk("pre_flush_valid", 32'(pkt_valid_o), 0);
      pulse_flush();
      chk("flush_valid", 32'(pkt_valid_o), 1);
      chk("flush_count", 32'(pkt_count_o), 5);
      accept();
      pulse_flush();
      @(negedge clk);
      chk("flush_empty_ignored", 32'(pkt_valid_o), 0);

      // No-op starts and stray done pulses while idle produce nothing.
      start_i = 1'b1;
      op_i    = 3'd0;
      for (int i = 0; i < 20; i++) begin
         done_i   = (i % 4 == 1);
         result_i = 16'hDEAD;
         @(negedge clk);
      end
      start_i  = 1'b0;
      done_i   = 1'b0;
      result_i = '0;
      pulse_flush();
      chk("nop_no_packet", 32'(pkt_valid_o), 0);
      p.cnt = 1;
      p.data = '0;
      p.data[31:0] = mkrec(207, 3, 2, 'h1234);
      sb_q.push_back(p);
      do_op(3'd3, 16'h1234, 2, 1'b0);
      pulse_flush();
      chk("after_nop_count", 32'(pkt_count_o), 1);
      accept();

      // Transfer on the same edge as a done: record goes to the new packet.
      p.cnt = 2;
      p.data = '0;
      p.data[31:0]  = mkrec(208, 6, 4, 'h0BEE);
      p.data[63:32] = mkrec(209, 7, 1, 'hCAFE);
      sb_q.push_back(p);
      do_op(3'd6, 16'h0BEE, 4, 1'b0);
      do_op(3'd7, 16'hCAFE, 1, 1'b0);
      pulse_flush();
      chk("pair_count", 32'(pkt_count_o), 2);
      p.cnt = 1;
      p.data = '0;
      p.data[31:0] = mkrec(210, 2, 3, 'h5555);
      sb_q.push_back(p);
      do_op(3'd2, 16'h5555, 3, 1'b1);
      chk("simul_drop_unchanged", 32'(drop_cnt_o), 10);
      chk("simul_valid_low", 32'(pkt_valid_o), 0);
      pulse_flush();
      chk("simul_count", 32'(pkt_count_o), 1);
      accept();

      // Reset while BUSY: op discarded, seq restarts at 0.
      start_i = 1'b1;
      op_i    = 3'd4;
      @(negedge clk);
      start_i = 1'b0;
      op_i    = 3'd0;
      @(negedge clk);
      reset_n_i = 1'b0;
      @(negedge clk);
      reset_n_i = 1'b1;
      done_i    = 1'b1;
      result_i  = 16'h9999;
      @(negedge clk);
      done_i   = 1'b0;
      result_i = '0;
      chk("rst_busy_valid", 32'(pkt_valid_o), 0);
      chk("rst_busy_drop", 32'(drop_cnt_o), 0);
      pulse_flush();
      chk("rst_busy_no_record", 32'(pkt_valid_o), 0);
      p.cnt = 1;
      p.data = '0;
      p.data[31:0] = mkrec(0, 5, 2, 'h0042);
      sb_q.push_back(p);
      do_op(3'd5, 16'h0042, 2, 1'b0);
      pulse_flush();
      chk("rst_seq0_count", 32'(pkt_count_o), 1);
      accept();

`ifdef ALU_COLLECTOR_TIMEOUT_EN
      // No done: timeout record after 31 cycles, late done ignored.
      p.cnt = 1;
      p.data = '0;
      p.data[31:0] = mkrec(1, 3, 31, 'hFFFF);
      sb_q.push_back(p);
      start_i = 1'b1;
      op_i    = 3'd3;
      @(negedge clk);
      start_i = 1'b0;
      op_i    = 3'd0;
      repeat (40) @(negedge clk);
      done_i   = 1'b1;
      result_i = 16'h7777;
      @(negedge clk);
      done_i   = 1'b0;
      result_i = '0;
      pulse_flush();
      chk("timeout_count", 32'(pkt_count_o), 1);
      accept();
`endif

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
